// File: rtl/fifo_wr_ctrl.sv
// Write-domain half of the async FIFO: drives the RAM write port, keeps binary/Gray
// write pointers, and derives full/level/handshakes. Optional macro: WR_CTRL_ALMOST_FULL_EN.
module fifo_wr_ctrl #(
  parameter int DEPTH        = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk_wr,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic                  en_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  almost_full
);

  localparam int PW = ADDR_WIDTH + 1;

  generate
    if ((DEPTH != (1 << ADDR_WIDTH)) || (DEPTH < 4) ||
        (AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_cfg
      $error("fifo_wr_ctrl: inconsistent DEPTH/ADDR_WIDTH/AFULL_THRESH");
    end
  endgenerate

  logic [PW-1:0] wr_bin, wr_bin_next, wr_gray_next;
  logic [PW-1:0] rd_bin, full_cmp, wr_level_next;
  logic          accept;

  assign accept = rst_n & wr_req & ~full;

  // RAM port is combinational so the word lands on the edge that advances the pointer
  assign en_wr   = accept;
  assign addr_wr = wr_bin[ADDR_WIDTH-1:0];
  assign data_wr = wr_din;

  assign wr_bin_next  = wr_bin + {{ADDR_WIDTH{1'b0}}, accept};
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);

  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) rd_bin[i] = ^(rd_ptr_gray_sync >> i);
  end

  // Full when write pointer is exactly one lap ahead: top two Gray bits inverted
  assign full_cmp = {~rd_ptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                     rd_ptr_gray_sync[ADDR_WIDTH-2:0]};

  assign wr_level_next = wr_bin_next - rd_bin;

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      wr_level    <= '0;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= wr_gray_next;
      full        <= (wr_gray_next == full_cmp);
      wr_level    <= wr_level_next;
      wr_ack      <= accept;
      overflow    <= wr_req & full;
    end
  end

`ifdef WR_CTRL_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) almost_full <= 1'b0;
    else        almost_full <= (wr_level_next >= AF_TH);
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus random traffic, checked every
// cycle against a count-based model of the FIFO (writes committed vs reads seen).
module tb_fifo_wr_ctrl;
  localparam int DEPTH = 16, DW = 8, AW = 4, AF = 12;

  logic          clk_wr = 1'b0;
  logic          rst_n, wr_req;
  logic [DW-1:0] wr_din;
  logic [AW:0]   rd_ptr_gray_sync;
  logic          en_wr, full, wr_ack, overflow, almost_full;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] data_wr;
  logic [AW:0]   wr_ptr_gray, wr_level;

  fifo_wr_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
    .clk_wr(clk_wr), .rst_n(rst_n), .wr_req(wr_req), .wr_din(wr_din),
    .rd_ptr_gray_sync(rd_ptr_gray_sync), .en_wr(en_wr), .addr_wr(addr_wr),
    .data_wr(data_wr), .wr_ptr_gray(wr_ptr_gray), .full(full), .wr_level(wr_level),
    .wr_ack(wr_ack), .overflow(overflow), .almost_full(almost_full));

  always #5 clk_wr = ~clk_wr;

  int n_cmp = 0, n_err = 0;
  // model: total writes committed, total reads seen, plus last-edge flags
  int wcnt = 0, rcnt = 0, m_full = 0, m_ack = 0, m_ovf = 0;

  function automatic logic [AW:0] b2g(int b);
    logic [AW:0] v;
    v = AW'(0) + (AW+1)'(b % (2*DEPTH));
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_regs();
    int lvl = wcnt - rcnt;
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(b2g(wcnt)));
    chk("wr_level", 32'(wr_level), lvl);
    chk("full", 32'(full), 32'(lvl == DEPTH));
    chk("wr_ack", 32'(wr_ack), m_ack);
    chk("overflow", 32'(overflow), m_ovf);
`ifdef WR_CTRL_ALMOST_FULL_EN
    chk("almost_full", 32'(almost_full), 32'(lvl >= AF));
`else
    chk("almost_full", 32'(almost_full), 0);
`endif
  endtask

  // one clock: drive at negedge, check RAM port, then check registers after the edge
  task automatic step(bit req, logic [DW-1:0] din, int rc);
    bit acc;
    @(negedge clk_wr);
    wr_req = req; wr_din = din; rcnt = rc; rd_ptr_gray_sync = b2g(rc);
    acc = req && !m_full;
    #1;
    chk("en_wr", 32'(en_wr), 32'(acc));
    if (acc) begin
      chk("addr_wr", 32'(addr_wr), wcnt % DEPTH);
      chk("data_wr", 32'(data_wr), 32'(din));
    end
    @(posedge clk_wr);
    m_ovf = int'(req && m_full);
    m_ack = int'(acc);
    wcnt += int'(acc);
    m_full = int'((wcnt - rcnt) == DEPTH);
    #1 chk_regs();
  endtask

  task automatic model_reset();
    wcnt = 0; rcnt = 0; m_full = 0; m_ack = 0; m_ovf = 0;
  endtask

  // asynchronous pulse between edges, with wr_req still asserted
  task automatic reset_pulse();
    @(posedge clk_wr);
    #3 wr_req = 1'b1; rst_n = 1'b0;
    #1;
    model_reset();
    rd_ptr_gray_sync = '0;
    chk("rst_en_wr", 32'(en_wr), 0);
    chk_regs();
    wr_req = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_req = 1'b1; wr_din = '0; rd_ptr_gray_sync = '0;
    // 1: held in reset with a pending request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_wr); #1;
      chk("rst_en_wr", 32'(en_wr), 0);
      chk("rst_gray", 32'(wr_ptr_gray), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_level", 32'(wr_level), 0);
    end
    @(negedge clk_wr); rst_n = 1'b1; wr_req = 1'b0;

    // 2: fill
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i*10), 0);
    chk("fill_gray_lit", 32'(wr_ptr_gray), 32'h18);
    chk("fill_full_lit", 32'(full), 1);
    chk("fill_level_lit", 32'(wr_level), 16);

    // 3: overflow while full
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hAA, 0);
      chk("ovf_lit", 32'(overflow), 1);
    end

    // 4: drain 4 then wrap
    step(1'b0, 8'h00, 4);
    chk("drain_level_lit", 32'(wr_level), 12);
    chk("drain_full_lit", 32'(full), 0);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(200 + i), 4);
    chk("wrap_gray_lit", 32'(wr_ptr_gray), 32'h1E);
    chk("wrap_full_lit", 32'(full), 1);

    // 5: simultaneous write and read advance at level 5
    step(1'b0, 8'h00, 15);
    chk("sim_pre_lit", 32'(wr_level), 5);
    step(1'b1, 8'h55, 17);
    chk("sim_level_lit", 32'(wr_level), 4);

    // random traffic, alternating slow-reader and fast-reader phases
    for (int i = 0; i < 600; i++) begin
      int rc, room, adv;
      rc = rcnt;
      room = wcnt - rcnt;
      if (((i / 60) % 2) == 0) adv = ($urandom_range(0, 5) == 0) ? 1 : 0;
      else adv = $urandom_range(0, 3);
      if (adv > room) adv = room;
      rc += adv;
      step($urandom_range(0, 3) != 0, DW'($urandom), rc);
    end

    // 6: reset mid-fill
    reset_pulse();
    for (int i = 0; i < 7; i++) step(1'b1, DW'(i + 1), 0);
    reset_pulse();
    step(1'b1, 8'h77, 0);
    chk("post_rst_level_lit", 32'(wr_level), 1);
    step(1'b0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-domain control stage of the asynchronous FIFO. It sits directly upstream of the dual-clock ram and drives that RAM's write port (en_wr, addr_wr, data_wr). It keeps the binary and Gray write pointers, and exports the Gray write pointer to the read-domain synchroniser. It takes in the read-domain Gray pointer, already synchronised to clk_wr, and uses it to generate full, fill level and overflow indications.

Parameters:
DEPTH, 16, FIFO/RAM entries; must be a power of two, at least 4.
DATA_WIDTH, 8, width of the data word.
ADDR_WIDTH, 4, RAM address width; must equal log2(DEPTH). Pointers are ADDR_WIDTH+1 bits wide.
AFULL_THRESH, 12, level at which almost_full asserts (optional feature only); valid range 1..DEPTH.

Ports:
clk_wr  input  1  write-domain clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
wr_req  input  1  producer write request.
wr_din  input  DATA_WIDTH  producer write data.
rd_ptr_gray_sync  input  ADDR_WIDTH+1  read Gray pointer, already synchronised into clk_wr.
en_wr  output  1  RAM write enable.
addr_wr  output  ADDR_WIDTH  RAM write address.
data_wr  output  DATA_WIDTH  RAM write data.
wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser.
full  output  1  FIFO full; registered.
wr_level  output  ADDR_WIDTH+1  registered fill level, 0..DEPTH.
wr_ack  output  1  one-cycle pulse, one clk_wr after an accepted write.
overflow  output  1  one-cycle pulse, one clk_wr after a rejected write.
almost_full  output  1  registered; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers clear.
  - wr_bin=0, wr_ptr_gray=0, full=0, wr_level=0, wr_ack=0, overflow=0, almost_full=0.
  - en_wr is forced to 0 while rst_n=0.
- Accept rule: accept = rst_n & wr_req & ~full.
- RAM write port is combinational, zero latency, so the RAM captures the word on the same edge the pointer advances:
  - en_wr = accept.
  - addr_wr = wr_bin[ADDR_WIDTH-1:0].
  - data_wr = wr_din.
- Next-pointer logic:
  - wr_bin_next = wr_bin + accept, modulo 2*DEPTH. The pointer wraps naturally; the MSB toggles on each pass.
  - wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1).
  - wr_ptr_gray <= wr_gray_next on every edge.
- Full logic:
  - full <= (wr_gray_next == {~rd_ptr_gray_sync[A:A-1], rd_ptr_gray_sync[A-2:0]}), where A = ADDR_WIDTH.
  - full asserts on the same edge that commits the DEPTH-th outstanding write.
  - full deasserts on the first clk_wr edge after rd_ptr_gray_sync advances. This is pessimistic by design and never optimistic.
- Level: wr_level <= wr_bin_next - gray2bin(rd_ptr_gray_sync), computed in ADDR_WIDTH+1 bits, modulo arithmetic.
- Handshake pulses:
  - wr_ack <= accept.
  - overflow <= rst_n & wr_req & full.
  - A rejected write leaves pointer, RAM and level unchanged.
- Simultaneous write and read-pointer change in one cycle: both apply. The level reflects +1 for the write and -delta for the read.
- No write when wr_req=0. wr_din is ignored when en_wr=0.
- Reset mid-operation:
  - Immediate clear and en_wr low.
  - The read side must be reset by the same rst_n. Behaviour with only one domain reset is not supported.

Optional Feature:
Macro: WR_CTRL_ALMOST_FULL_EN.
- Defined: almost_full <= (wr_level_next >= AFULL_THRESH), registered, updating on the same edge as wr_level.
- Undefined: almost_full is tied to 0 and no comparator logic is generated. The port list is unchanged in both builds.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with wr_req=1 -> en_wr=0, wr_ptr_gray=5'b00000, full=0, wr_level=0 throughout.
2. Fill: rd_ptr_gray_sync=0, wr_req=1, wr_din=i*10 for 16 cycles -> en_wr=1 with addr_wr=0..15 and data_wr=0..150; wr_ptr_gray ends at 5'b11000; full=1 and wr_level=16 after the 16th edge.
3. Overflow: with the FIFO full, set wr_req=1, wr_din=8'hAA for 2 cycles -> en_wr=0, addr_wr held at 0, overflow pulses on both cycles, wr_ack=0, wr_level stays 16.
4. Drain and wrap: from full, set rd_ptr_gray_sync=5'b00110 (bin 4) -> full=0 and wr_level=12 one edge later. Write 4 more -> addr_wr=0..3, wr_ptr_gray=gray(20)=5'b11110, full=1.
5. Simultaneous: at level 5, in the same cycle rd_ptr_gray_sync advances by 2 and one write is accepted -> wr_level=4 next edge.
6. Reset mid-fill: after 7 writes, pulse rst_n low asynchronously between edges -> all outputs zero immediately. After release, the next write uses addr_wr=0.
   - With WR_CTRL_ALMOST_FULL_EN defined: almost_full rises on the 12th write of scenario 2.
   - Without the macro: almost_full stays 0 throughout.
